// File: rtl/fetch_queue_unit.sv
// RV32I fetch stage: owns the PC, drives a 1-cycle-latency instruction memory and
// buffers (pc, instr) pairs for decode. Optional macro FETCH_MISALIGN_CHK_EN flags misaligned PCs.
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DepthCredit = (AW+2)'(DEPTH);
  localparam logic [AW:0]   DepthCount  = (AW+1)'(DEPTH);

`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic [31:0] StartPc = RESET_PC;
`else
  localparam logic [31:0] StartPc = RESET_PC & ~32'h3;
`endif

  logic [31:0]   redirTarget;
  logic [31:0]   fetchPc_q;
  logic [31:0]   fetchPc_d;
  logic          inflight_q;
  logic          inflight_d;
  logic [31:0]   inflightPc_q;
  logic [31:0]   inflightPc_d;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic [AW-1:0] rdPtr_q;
  logic [AW-1:0] rdPtr_d;
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] wrPtr_d;
  logic [31:0]   pcMem_q    [DEPTH];
  logic [31:0]   instrMem_q [DEPTH];
  logic [AW+1:0] creditUsed;
  logic          issue;
  logic          push;
  logic          pop;
  logic          headValid;

`ifdef FETCH_MISALIGN_CHK_EN
  logic          misMem_q [DEPTH];
  assign redirTarget = redirect_pc;
`else
  assign redirTarget = redirect_pc & ~32'h3;
`endif

  assign headValid = (count_q != '0);
  assign out_valid = headValid && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q && !redirect_valid;

  // Credits count queued entries plus the response still in the memory pipe, so a
  // new issue is only made when its response is guaranteed a free slot.
  assign creditUsed = {1'b0, count_q} + (AW+2)'(inflight_q) - (AW+2)'(pop);
  assign issue      = rst_n && (redirect_valid || (fetch_en && (creditUsed < DepthCredit)));

  assign imem_en   = issue;
  assign imem_addr = redirect_valid ? redirTarget : fetchPc_q;

  assign out_pc    = out_valid ? pcMem_q[rdPtr_q]    : 32'h0;
  assign out_instr = out_valid ? instrMem_q[rdPtr_q] : NOP_WORD;
`ifdef FETCH_MISALIGN_CHK_EN
  assign out_misalign = out_valid && misMem_q[rdPtr_q];
`else
  assign out_misalign = 1'b0;
`endif

  always_comb begin
    fetchPc_d    = fetchPc_q;
    inflight_d   = issue;
    inflightPc_d = inflightPc_q;
    count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
    rdPtr_d      = rdPtr_q + (pop  ? AW'(1) : AW'(0));
    wrPtr_d      = wrPtr_q + (push ? AW'(1) : AW'(0));
    if (issue) begin
      fetchPc_d    = imem_addr + 32'd4;
      inflightPc_d = imem_addr;
    end
    // A redirect flushes the queue and drops whatever response is still arriving.
    if (redirect_valid) begin
      count_d = '0;
      rdPtr_d = '0;
      wrPtr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchPc_q    <= StartPc;
      inflight_q   <= 1'b0;
      inflightPc_q <= 32'h0;
      count_q      <= '0;
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
    end else begin
      fetchPc_q    <= fetchPc_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
      count_q      <= count_d;
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pcMem_q[wrPtr_q]    <= inflightPc_q;
      instrMem_q[wrPtr_q] <= imem_instr;
`ifdef FETCH_MISALIGN_CHK_EN
      misMem_q[wrPtr_q]   <= (inflightPc_q[1:0] != 2'b00);
`endif
    end
  end

  overflowChk: assert property (@(posedge clk) disable iff (!rst_n)
                                !(push && !pop && (count_q == DepthCount)));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit with a synchronous-address instruction memory model.
module tb_fetch_queue_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic [31:0] MisBase = 32'h0000_0042;
  localparam logic        MisFlag = 1'b1;
`else
  localparam logic [31:0] MisBase = 32'h0000_0040;
  localparam logic        MisFlag = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imemInstr = NOP;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misalign;

  entry_t expQ[$];
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2),
    .NOP_WORD(NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_instr    (imemInstr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_misalign  (out_misalign)
  );

  // Word i of the preloaded region holds 0x1000_0000+i; everything else reads as NOP.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a < 32'h100) ? (32'h1000_0000 + (a >> 2)) : NOP;
  endfunction

  always @(posedge clk) begin
    if (imem_en) imemInstr <= memWord(imem_addr);
  end

  always @(negedge clk) begin
    entry_t e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected entry: got pc=%h instr=%h, required none", out_pc, out_instr);
      end else begin
        e = expQ.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr || out_misalign !== e.mis) begin
          errors++;
          $display("[TB] FAIL entry: got pc=%h instr=%h mis=%b, required pc=%h instr=%h mis=%b",
                   out_pc, out_instr, out_misalign, e.pc, e.instr, e.mis);
        end
      end
    end
  end

  task automatic expectSeq(input logic [31:0] startPc, input int n);
    entry_t e;
    for (int k = 0; k < n; k++) begin
      e.pc    = startPc + 32'(4 * k);
      e.instr = memWord(e.pc);
`ifdef FETCH_MISALIGN_CHK_EN
      e.mis   = (e.pc[1:0] != 2'b00);
`else
      e.mis   = 1'b0;
`endif
      expQ.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;

    @(negedge clk);
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst out_pc", out_pc, 32'h0);
    checkOutput("rst out_instr", out_instr, NOP);
    checkOutput("rst out_misalign", 32'(out_misalign), 32'd0);
    checkOutput("rst imem_en", 32'(imem_en), 32'd0);

    // Streaming from reset with decode always ready.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expectSeq(32'h0, 40);
    @(negedge clk);
    checkOutput("c0 imem_en", 32'(imem_en), 32'd1);
    checkOutput("c0 imem_addr", imem_addr, 32'h0);
    checkOutput("c0 out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("c1 out_valid", 32'(out_valid), 32'd0);
    checkOutput("c1 imem_addr", imem_addr, 32'h4);
    for (int c = 2; c <= 5; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("stream valid", 32'(out_valid), 32'd1);
      checkOutput("stream pc", out_pc, 32'(4 * (c - 2)));
    end

    // Backpressure: queue fills, fetch stalls, head holds.
    for (int c = 6; c <= 10; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput("stall valid", 32'(out_valid), 32'd1);
      checkOutput("stall pc", out_pc, 32'h10);
      checkOutput("stall instr", out_instr, 32'h1000_0004);
      checkOutput("stall imem_en", 32'(imem_en), 32'd0);
    end
    for (int c = 11; c <= 13; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("resume pc", out_pc, 32'h10 + 32'(4 * (c - 11)));
    end

    // Redirect while the queue is full.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0);
    expQ.delete();
    expectSeq(32'h40, 8);
    @(negedge clk);
    checkOutput("redir out_valid", 32'(out_valid), 32'd0);
    checkOutput("redir imem_en", 32'(imem_en), 32'd1);
    checkOutput("redir imem_addr", imem_addr, 32'h40);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("redir+1 out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("redir+2 pc", out_pc, 32'h40);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("redir+3 pc", out_pc, 32'h44);

    // Redirect against an accepted head, fetch disabled: exactly one entry.
    applyStimulus(1'b0, 1'b1, 32'h80, 1'b1);
    expQ.delete();
    expectSeq(32'h80, 1);
    @(negedge clk);
    checkOutput("pop-redir out_valid", 32'(out_valid), 32'd0);
    checkOutput("pop-redir imem_addr", imem_addr, 32'h80);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("single imem_en", 32'(imem_en), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("single pc", out_pc, 32'h80);
    for (int c = 22; c <= 23; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput("single idle valid", 32'(out_valid), 32'd0);
    end
    checkOutput("single drained", 32'(expQ.size()), 32'd0);

    // PC wraps past the top of the address space.
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    expQ.delete();
    expectSeq(32'hFFFF_FFFC, 4);
    @(negedge clk);
    checkOutput("wrap imem_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("wrap next addr", imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("wrap top instr", out_instr, NOP);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("wrap zero pc", out_pc, 32'h0);
    for (int c = 28; c <= 31; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    end
    @(negedge clk);
    checkOutput("wrap idle valid", 32'(out_valid), 32'd0);
    checkOutput("wrap drained", 32'(expQ.size()), 32'd0);

    // Misaligned redirect target.
    applyStimulus(1'b0, 1'b1, 32'h42, 1'b1);
    expQ.push_back('{pc: MisBase, instr: 32'h1000_0010, mis: MisFlag});
    @(negedge clk);
    checkOutput("mis imem_addr", imem_addr, MisBase);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("mis pc", out_pc, MisBase);
    checkOutput("mis flag", 32'(out_misalign), 32'(MisFlag));
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("mis drained", 32'(expQ.size()), 32'd0);

    // Asynchronous reset in the middle of a filling queue.
    expectSeq(MisBase + 32'h4, 4);
    for (int c = 36; c <= 38; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    end
    @(negedge clk);
    checkOutput("prerst valid", 32'(out_valid), 32'd1);
    checkOutput("prerst pc", out_pc, MisBase + 32'h4);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst out_pc", out_pc, 32'h0);
    checkOutput("arst out_instr", out_instr, NOP);
    checkOutput("arst imem_en", 32'(imem_en), 32'd0);
    checkOutput("arst imem_addr", imem_addr, 32'h0);
    checkOutput("arst out_misalign", 32'(out_misalign), 32'd0);
    expQ.delete();

    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    expectSeq(32'h0, 8);
    @(negedge clk);
    checkOutput("rerun imem_addr", imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("rerun pc", out_pc, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
